axi_r_to_stream: RTL and testbench

- AXI read-data (R) channel tap. It is the return-path counterpart of the write-data stream tap.
- Forwards R beats from the downstream memory side (AXIM_r*) to the upstream initiator (AXIS_r*). Every forwarded beat is also captured into an internal FIFO.
- The FIFO is drained onto the shared monitor stream: one header word per burst, then one word per beat.
- Participates in the stream arbiter through the ready, valid and in_progress signals.

---
 rtl/axi_r_to_stream.sv | 157 +++++++++++++++
 tb/tb_axi_r_to_stream.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_r_to_stream.sv
// AXI R-channel tap: forwards R beats memory->initiator and copies each
// accepted beat into a FIFO that is replayed onto the shared monitor stream.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   ready               arbiter grant; a word moves when valid && ready
//   valid, data         monitor stream word (header, then one per beat)
//   in_progress         stream owned from header until the burst's last beat
//   AXIM_r*             R beat from the memory side (AXIM_rready returned)
//   AXIS_r*             R beat forwarded to the initiator (AXIS_rready in)
module axi_r_to_stream #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH = 32,
  parameter int USER_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = 3'b001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  output logic                  valid,
  output logic                  in_progress,
  output logic [DATA_WIDTH-1:0] data,
  input  logic [ID_WIDTH-1:0]   AXIM_rid,
  input  logic [DATA_WIDTH-1:0] AXIM_rdata,
  input  logic [1:0]            AXIM_rresp,
  input  logic                  AXIM_rlast,
  input  logic [USER_WIDTH-1:0] AXIM_ruser,
  input  logic                  AXIM_rvalid,
  output logic                  AXIM_rready,
  output logic [ID_WIDTH-1:0]   AXIS_rid,
  output logic [DATA_WIDTH-1:0] AXIS_rdata,
  output logic [1:0]            AXIS_rresp,
  output logic                  AXIS_rlast,
  output logic [USER_WIDTH-1:0] AXIS_ruser,
  output logic                  AXIS_rvalid,
  input  logic                  AXIS_rready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ID_WIDTH + 3 + DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full, empty;
  logic          push, pop;

  logic [EW-1:0]         head;
  logic [ID_WIDTH-1:0]   head_rid;
  logic [1:0]            head_rresp;
  logic                  head_rlast;
  logic [DATA_WIDTH-1:0] head_rdata;
  logic [DATA_WIDTH-1:0] hdr_word;

  // Pass-through: both sides see one shared handshake, gated by full
  // so a forwarded beat is always captured.
  assign AXIS_rid    = AXIM_rid;
  assign AXIS_rdata  = AXIM_rdata;
  assign AXIS_rresp  = AXIM_rresp;
  assign AXIS_rlast  = AXIM_rlast;
  assign AXIS_ruser  = AXIM_ruser;
  assign AXIS_rvalid = AXIM_rvalid && !full;
  assign AXIM_rready = AXIS_rready && !full;

  assign push  = AXIM_rvalid && AXIS_rready && !full;
  assign empty = (count == '0);

  assign head = mem[rd_ptr];
  assign {head_rid, head_rresp, head_rlast, head_rdata} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {AXIM_rid, AXIM_rresp, AXIM_rlast, AXIM_rdata};
    end
  end

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // full is a register, so a pop never frees a slot for the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[ID_WIDTH-1:0] = head_rid;
    hdr_word[ID_WIDTH+1:ID_WIDTH] = head_rresp;
    hdr_word[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The header only peeks at the head beat; data words pop it.
  // An empty FIFO mid-burst keeps the stream locked in DATA.
  always_comb begin
    state_nxt   = state;
    valid       = 1'b0;
    in_progress = 1'b0;
    data        = '0;
    pop         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nxt = HDR;
      end
      HDR: begin
        valid       = 1'b1;
        in_progress = 1'b1;
        data        = hdr_word;
        if (ready) state_nxt = DATA;
      end
      DATA: begin
        in_progress = 1'b1;
        valid       = !empty;
        if (!empty) begin
          data = head_rdata;
          if (ready) begin
            pop = 1'b1;
            if (head_rlast) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_r_to_stream.sv
// Scoreboard bench for axi_r_to_stream: accepted beats queue their
// expected stream words; a negedge monitor pops and compares.
module tb_axi_r_to_stream;

  logic         clk;
  logic         reset;
  logic         ready;
  logic         valid;
  logic         in_progress;
  logic [127:0] data;
  logic [31:0]  AXIM_rid;
  logic [127:0] AXIM_rdata;
  logic [1:0]   AXIM_rresp;
  logic         AXIM_rlast;
  logic [63:0]  AXIM_ruser;
  logic         AXIM_rvalid;
  logic         AXIM_rready;
  logic [31:0]  AXIS_rid;
  logic [127:0] AXIS_rdata;
  logic [1:0]   AXIS_rresp;
  logic         AXIS_rlast;
  logic [63:0]  AXIS_ruser;
  logic         AXIS_rvalid;
  logic         AXIS_rready;

  axi_r_to_stream dut (
    .clk(clk),
    .reset(reset),
    .ready(ready),
    .valid(valid),
    .in_progress(in_progress),
    .data(data),
    .AXIM_rid(AXIM_rid),
    .AXIM_rdata(AXIM_rdata),
    .AXIM_rresp(AXIM_rresp),
    .AXIM_rlast(AXIM_rlast),
    .AXIM_ruser(AXIM_ruser),
    .AXIM_rvalid(AXIM_rvalid),
    .AXIM_rready(AXIM_rready),
    .AXIS_rid(AXIS_rid),
    .AXIS_rdata(AXIS_rdata),
    .AXIS_rresp(AXIS_rresp),
    .AXIS_rlast(AXIS_rlast),
    .AXIS_ruser(AXIS_ruser),
    .AXIS_rvalid(AXIS_rvalid),
    .AXIS_rready(AXIS_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    bit           last;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   xfers = 0;
  bit   chk_idle = 0;
  int   rmode = 0;

  function automatic logic [127:0] hdr(input logic [31:0] id,
                                       input logic [1:0] resp);
    logic [127:0] h;
    h = '0;
    h[31:0] = id;
    h[33:32] = resp;
    h[127:125] = 3'b001;
    return h;
  endfunction

  // Arbiter grant: 0 low, 1 high, 2 toggle, 3 random.
  initial begin
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: ready = 1'b0;
        1: ready = 1'b1;
        2: ready = ~ready;
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        checks++;
        if (in_progress || valid) begin
          failures++;
          $display("FAIL idle_gap valid=%0b in_progress=%0b need 0/0",
                   valid, in_progress);
        end
        chk_idle = 0;
      end
      checks++;
      if (!valid && data !== '0) begin
        failures++;
        $display("FAIL data_zero got=%h need 0", data);
      end else if (valid && !in_progress) begin
        failures++;
        $display("FAIL owner in_progress=0 while valid=1");
      end
      if (valid && ready) begin
        xfers++;
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word got=%h need none", data);
        end else begin
          e = expq.pop_front();
          if (data !== e.d) begin
            failures++;
            $display("FAIL stream_word got=%h need %h", data, e.d);
          end
          if (e.last) chk_idle = 1;
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] id, input logic [1:0] resp,
                           input bit last, input logic [127:0] d,
                           input bit first, input int stall);
    int n;
    bit ok;
    logic [63:0] u;
    exp_t x;
    u = {$urandom, $urandom};
    AXIM_rid = id;
    AXIM_rresp = resp;
    AXIM_rlast = last;
    AXIM_rdata = d;
    AXIM_ruser = u;
    AXIM_rvalid = 1'b1;
    AXIS_rready = (stall == 0);
    n = 0;
    ok = 0;
    forever begin
      @(negedge clk);
      checks++;
      if (AXIS_rid !== id || AXIS_rdata !== d || AXIS_rresp !== resp ||
          AXIS_rlast !== last || AXIS_ruser !== u) begin
        failures++;
        $display("FAIL passthru got id=%h resp=%0d last=%0b need %h/%0d/%0b",
                 AXIS_rid, AXIS_rresp, AXIS_rlast, id, resp, last);
      end
      checks++;
      if (!AXIS_rready && AXIM_rready !== 1'b0) begin
        failures++;
        $display("FAIL rready_gate got=%0b need 0", AXIM_rready);
      end else if (AXIS_rready && AXIS_rvalid !== AXIM_rready) begin
        failures++;
        $display("FAIL hs_match rvalid=%0b rready=%0b need equal",
                 AXIS_rvalid, AXIM_rready);
      end
      if (AXIS_rready && AXIM_rready) begin
        ok = 1;
        break;
      end
      n++;
      if (n > 300) break;
      @(posedge clk);
      #1;
      if (n >= stall) AXIS_rready = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout id=%h got no accept need accept", id);
    end else begin
      if (first) begin
        x.d = hdr(id, resp);
        x.last = 0;
        expq.push_back(x);
      end
      x.d = d;
      x.last = last;
      expq.push_back(x);
    end
    @(posedge clk);
    #1;
    AXIM_rvalid = 1'b0;
    AXIS_rready = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d need 0", expq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string nm, input logic got,
                           input logic need);
    checks++;
    if (got !== need) begin
      failures++;
      $display("FAIL %s got=%0b need %0b", nm, got, need);
    end
  endtask

  initial begin
    int n;
    int base;
    int len;
    int gap;
    logic [31:0] id0;
    logic [31:0] idb;
    reset = 1'b1;
    AXIM_rid = '0;
    AXIM_rdata = '0;
    AXIM_rresp = '0;
    AXIM_rlast = 1'b0;
    AXIM_ruser = '0;
    AXIM_rvalid = 1'b0;
    AXIS_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_bit("rst_valid", valid, 1'b0);
    check_bit("rst_in_progress", in_progress, 1'b0);
    check_bit("rst_data_zero", data == '0, 1'b1);
    check_bit("rst_rready", AXIM_rready, 1'b1);

    // Single beat and header latency.
    rmode = 1;
    @(posedge clk);
    #1;
    send_beat(32'h5, 2'd0, 1, {16{8'hA5}}, 1, 0);
    @(negedge clk);
    check_bit("lat_idle_valid", valid, 1'b0);
    @(negedge clk);
    check_bit("lat_hdr_valid", valid, 1'b1);
    check_bit("lat_hdr_owner", in_progress, 1'b1);
    drain();

    // 4-beat burst, grant toggling.
    rmode = 2;
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h3, 2'd0, i == 3, 128'(i + 1), i == 0, 0);
    end
    drain();

    // Backpressure: 16 fit, the 17th stalls until the stream drains.
    rmode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      send_beat(32'h7, 2'd0, 0, 128'(100 + i), i == 0, 0);
    end
    AXIM_rid = 32'h7;
    AXIM_rdata = 128'(116);
    AXIM_rresp = 2'd0;
    AXIM_rlast = 1'b0;
    AXIM_rvalid = 1'b1;
    AXIS_rready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_bit("full_rready", AXIM_rready, 1'b0);
      check_bit("full_rvalid", AXIS_rvalid, 1'b0);
      @(posedge clk);
      #1;
    end
    rmode = 1;
    for (int i = 16; i < 20; i++) begin
      send_beat(32'h7, 2'd0, i == 19, 128'(100 + i), 0, 0);
    end
    drain();

    // Back-to-back bursts.
    send_beat(32'h1, 2'd0, 0, 128'h11, 1, 0);
    send_beat(32'h1, 2'd0, 1, 128'h12, 0, 0);
    send_beat(32'h2, 2'd2, 0, 128'h21, 1, 0);
    send_beat(32'h2, 2'd2, 1, 128'h22, 0, 0);
    drain();

    // Initiator not ready: nothing may be captured.
    AXIM_rid = 32'h44;
    AXIM_rdata = 128'h44;
    AXIM_rlast = 1'b1;
    AXIM_rvalid = 1'b1;
    AXIS_rready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_bit("nordy_rready", AXIM_rready, 1'b0);
      check_bit("nordy_rvalid", AXIS_rvalid, 1'b1);
      @(posedge clk);
      #1;
    end
    AXIM_rvalid = 1'b0;
    AXIS_rready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Reset after header plus one data word.
    rmode = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h9, 2'd1, i == 3, 128'(200 + i), i == 0, 0);
    end
    base = xfers;
    rmode = 1;
    n = 0;
    while (xfers < base + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    rmode = 0;
    check_bit("rst_mid_reach", xfers >= base + 2, 1'b1);
    #1;
    reset = 1'b1;
    expq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_bit("rstm_valid", valid, 1'b0);
    check_bit("rstm_in_progress", in_progress, 1'b0);
    check_bit("rstm_rready", AXIM_rready, 1'b1);
    rmode = 1;
    repeat (5) @(posedge clk);
    #1;
    send_beat(32'h11, 2'd0, 1, 128'hBEEF, 1, 0);
    drain();

    // Random bursts, random grant and initiator stalls.
    rmode = 3;
    for (int b = 0; b < 30; b++) begin
      len = $urandom_range(1, 5);
      id0 = $urandom;
      for (int i = 0; i < len; i++) begin
        idb = (i > 0 && $urandom_range(0, 3) == 0) ? $urandom : id0;
        send_beat(idb, 2'($urandom_range(0, 3)), i == len - 1,
                  {$urandom, $urandom, $urandom, $urandom}, i == 0,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    rmode = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
